// File: rtl/mem_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// mem_cmd_sequencer
//
// Command front-end for the combined ROM + bitwise-RAM memory system. Write
// and read commands are queued in a small FIFO and issued one at a time. A
// write drives one RAM-update cycle (data OP ROM[addr]) followed by a
// read-back cycle, so every command returns the value actually held in RAM
// on a valid/ready response port.
//
// Ports
//   CLK, RST            rising-edge clock, asynchronous active-high reset
//   cmdValid/cmdReady   command handshake (cmdReady = FIFO not full)
//   cmdMode             0 = write (bitwise op with ROM), 1 = read
//   cmdAddr/Op/Data     command address, operation, write operand
//   memMode/Addr/Op/    registered drive to the memory system
//   memDataIn
//   memDataOut          memory system output, sampled at the end of READ
//   rspValid/rspReady   response handshake
//   rspAddr/rspData     address and captured data of the finished command
//   doneCount           completed writes, wraps 255 -> 0
// -----------------------------------------------------------------------------
module mem_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdMode,
  input  logic [2:0] cmdAddr,
  input  logic [1:0] cmdOp,
  input  logic [7:0] cmdData,
  output logic       memMode,
  output logic [2:0] memAddr,
  output logic [1:0] memOp,
  output logic [7:0] memDataIn,
  input  logic [7:0] memDataOut,
  output logic       rspValid,
  input  logic       rspReady,
  output logic [2:0] rspAddr,
  output logic [7:0] rspData,
  output logic [7:0] doneCount
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic       mode;
    logic [2:0] addr;
    logic [1:0] op;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  // FIFO
  cmd_t          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  cmd_t          cmd_in, head;
  logic          push, pop;

  // FSM and output registers
  state_t      state_q, state_d;
  logic        mem_mode_q;
  logic [2:0]  mem_addr_q;
  logic [1:0]  mem_op_q;
  logic [7:0]  mem_data_q;
  logic        from_write_q;
  logic        rsp_valid_q;
  logic [2:0]  rsp_addr_q;
  logic [7:0]  rsp_data_q;
  logic [7:0]  done_q;

  assign cmdReady = (count_q != CNT_FULL);
  assign push     = cmdValid && cmdReady;
  assign cmd_in   = {cmdMode, cmdAddr, cmdOp, cmdData};
  assign head     = fifo_q[rd_ptr_q];

  // NOTE: FIFO storage has no reset; an entry is only read after the pointer
  // logic (which is reset) says it was written, so clearing it buys nothing.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_in;
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = head.mode ? READ : WRITE;
        end
      end
      WRITE:   state_d = READ;
      READ:    state_d = RESP;
      RESP:    if (rspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_mode_q   <= 1'b1;
      mem_addr_q   <= '0;
      mem_op_q     <= '0;
      mem_data_q   <= '0;
      from_write_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_data_q   <= '0;
      done_q       <= '0;
    end else begin
      state_q <= state_d;

      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (!push && pop) count_q <= count_q - CNT_ONE;

      // Outputs are registered from the next state so they line up with it.
      mem_mode_q  <= (state_d != WRITE);
      rsp_valid_q <= (state_d == RESP);

      // The mem address/op/data registers double as the command register.
      // Reads leave op/data untouched since the memory ignores them.
      if (pop) begin
        mem_addr_q   <= head.addr;
        from_write_q <= !head.mode;
        if (!head.mode) begin
          mem_op_q   <= head.op;
          mem_data_q <= head.data;
        end
      end

      if (state_q == READ) begin
        rsp_data_q <= memDataOut;
        rsp_addr_q <= mem_addr_q;
        if (from_write_q) done_q <= done_q + 8'd1;
      end
    end
  end

  assign memMode   = mem_mode_q;
  assign memAddr   = mem_addr_q;
  assign memOp     = mem_op_q;
  assign memDataIn = mem_data_q;
  assign rspValid  = rsp_valid_q;
  assign rspAddr   = rsp_addr_q;
  assign rspData   = rsp_data_q;
  assign doneCount = done_q;

endmodule
